uart_rx: RTL
============

# uart_rx

Serial receiver for the UART peripheral: the receive-side counterpart of the existing TX path. It samples `rxd` at 16x the bit rate using the shared sample-clock enable and recovers start, data, parity and stop bits. Each received frame appears as a one-cycle valid pulse with right-aligned data and per-frame parity and stop-bit error flags. The UART datapath pushes the result into the RX queue and folds the error flags into the interrupt flag register.

## Interface
- `OVERSAMPLE`, default 16: `sample_en` ticks per bit; must be at least 8 and even.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `sample_en`  input  1  one-`clk` pulse at 16x the baud rate (sample clock counter top).
- `rxd`  input  1  raw serial line, idle high; asynchronous to `clk`.
- `data_bits_count`  input  2  number of data bits = value + 5 (5..8).
- `parity_type`  input  2  bit 0 = parity enable, bit 1 = odd (1) or even (0).
- `double_stop_bits`  input  1  expect 2 stop bits when high.
- `rx_data`  output  8  last received byte, right-aligned, unused MSBs are 0.
- `rx_valid`  output  1  one-`clk` pulse when a frame completes.
- `parity_error`  output  1  qualified by `rx_valid`; received parity mismatch.
- `stop_bit_error`  output  1  qualified by `rx_valid`; a stop bit sampled as 0.
- `busy`  output  1  high from start detection until return to IDLE.

## Operation
- **Synchronizer:** `rxd` passes through a 2-FF synchronizer (reset value 1) to give `rxd_s`. All decisions use `rxd_s`.
- **Tick counter:** counts `sample_en` pulses from 0 to OVERSAMPLE-1 within each bit and wraps to 0 at each bit boundary.
- **Bit value:** majority vote of `rxd_s` sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is made on the tick OVERSAMPLE/2+1.
- **Config latching:** config inputs are latched when leaving IDLE. Changes during a frame have no effect on that frame.
- **IDLE:** on a `sample_en` tick with `rxd_s`=0, set tick=0 and go to START.
- **START:** at the decision tick:
  - voted 1 means a false start; return to IDLE and do not assert `rx_valid`.
  - otherwise, at tick OVERSAMPLE-1 go to DATA.
- **DATA:** the voted bit shifts into the MSB of an 8-bit shift register (LSB-first line order).
  - After N = `data_bits_count`+5 bits, go to PARITY if enabled, else STOP1.
  - The bit counter is 3 bits wide, and N=8 is handled without overflow.
- **PARITY:** the expected bit is the XOR of the data bits, inverted when odd parity is selected. A mismatch sets the internal parity flag.
- **STOP1:** voted 0 sets the stop flag.
  - If `double_stop_bits`=0, the frame completes at this decision tick.
  - Otherwise, at tick OVERSAMPLE-1 go to STOP2.
- **STOP2:** same as STOP1; the frame always completes at this decision tick.
- **Frame complete:**
  - `rx_data` takes the shift register shifted right by 8-N.
  - The error outputs take the internal flags.
  - `rx_valid` pulses, and the FSM returns to IDLE immediately, so a start edge in the second half of the stop bit is caught.
- **Error flags:** both internal flags clear on start detection.
- **No backpressure:** the consumer must accept data on the `rx_valid` pulse. `rx_data` holds until the next `rx_valid`.

## Timing
- **Reset values:**
  - `rx_data`=0, `rx_valid`=0, `parity_error`=0, `stop_bit_error`=0, `busy`=0.
  - FSM in IDLE, synchronizer at 1, tick counter and bit counter at 0.
- **Reset mid-frame:** immediately abandons the frame with no `rx_valid`. After release, the receiver waits for a fresh falling edge.
- **Synchronizer latency:** 2 `clk` cycles from `rxd` to `rxd_s`.
- **Output timing:**
  - `rx_valid`, `rx_data` and the error flags all become valid in the `clk` cycle after the final stop-bit decision tick.
  - `rx_valid` is high for exactly one `clk`.
- **`busy` timing:** rises in the cycle after the start-detect tick. It falls in the same cycle that `rx_valid` rises, or in the cycle after a false-start decision.
- **Frame length:** a frame from start detection to `rx_valid` spans (1 + N + P + S - 1) × OVERSAMPLE + OVERSAMPLE/2 + 2 `sample_en` ticks, plus one `clk`.
- **Start edge during a stop bit:** a falling edge during the first half of a stop bit is ignored until the FSM reaches IDLE.
- **`sample_en` and reset asserted together:** reset wins.

## Test plan
- **8N1 byte:** 8N1, `sample_en` every 14 `clk`, send 0xA5.
  - Expect `rx_valid` pulse, `rx_data`=0xA5, both errors 0, `busy` low after.
- **5E1 correct parity:** 5 bits, even parity, send 0x13 with parity bit 1.
  - Expect `rx_data`=0x13, `parity_error`=0.
  - Repeat with parity bit 0: `parity_error`=1 and data still 0x13.
- **7O2 stop-bit error:** 7 bits, odd parity, 2 stop bits, send 0x55 with the second stop bit held low.
  - Expect `stop_bit_error`=1, `parity_error`=0, `rx_data`=0x55.
- **Glitch:** low pulse of 4 ticks on idle line.
  - Expect `busy` pulse, no `rx_valid`, return to IDLE.
  - A subsequent 0x3C frame is received correctly.
- **Back-to-back:** 0x00 then 0xFF with the second start edge at tick 10 of the stop bit.
  - Expect two `rx_valid` pulses with 0x00 then 0xFF.
- **Mid-frame reset:** assert `reset` during data bit 3 of 0x81, then send 0x7E.
  - All outputs read 0 during reset, no `rx_valid` for the aborted frame, and next `rx_data`=0x7E.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with majority-vote bit recovery,
// 5..8 data bits, optional even/odd parity and one or two stop bits.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       rxd,
    input  logic [1:0] data_bits_count,
    input  logic [1:0] parity_type,
    input  logic       double_stop_bits,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stop_bit_error,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t          state, state_nx;
    logic            rxd_m, rxd_s;
    logic [TW-1:0]   tick;
    logic [2:0]      bit_cnt, last_bit;
    logic [7:0]      shift;
    logic            s_lo, s_mid, vote;
    logic            at_dec, at_last, start_det, done;
    logic            par_en, par_odd, dbl;
    logic            par_flag, stop_flag;

    assign at_dec    = sample_en && tick == T_DEC;
    assign at_last   = sample_en && tick == T_LAST;
    assign vote      = (s_lo & s_mid) | (s_lo & rxd_s) | (s_mid & rxd_s);
    assign start_det = state == IDLE && sample_en && !rxd_s;
    assign done      = at_dec && (state == STOP2 || (state == STOP1 && !dbl));
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_det) state_nx = START;
            START:
                if (at_dec && vote)
                    state_nx = IDLE;
                else if (at_last)
                    state_nx = DATA;
            DATA:    if (at_last && bit_cnt == last_bit) state_nx = par_en ? PARITY : STOP1;
            PARITY:  if (at_last) state_nx = STOP1;
            STOP1:
                if (done)
                    state_nx = IDLE;
                else if (at_last)
                    state_nx = STOP2;
            STOP2:   if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_m          <= 1'b1;
            rxd_s          <= 1'b1;
            tick           <= '0;
            bit_cnt        <= '0;
            last_bit       <= '0;
            shift          <= '0;
            s_lo           <= 1'b0;
            s_mid          <= 1'b0;
            par_en         <= 1'b0;
            par_odd        <= 1'b0;
            dbl            <= 1'b0;
            par_flag       <= 1'b0;
            stop_flag      <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            parity_error   <= 1'b0;
            stop_bit_error <= 1'b0;
        end else begin
            rxd_m    <= rxd;
            rxd_s    <= rxd_m;
            rx_valid <= done;
            if (state == IDLE)
                tick <= '0;
            else if (sample_en)
                tick <= at_last ? '0 : tick + 1'b1;
            if (sample_en && tick == T_LO)
                s_lo <= rxd_s;
            if (sample_en && tick == T_MID)
                s_mid <= rxd_s;
            // Frame configuration is frozen here so mid-frame register writes are harmless
            if (start_det) begin
                par_en    <= parity_type[0];
                par_odd   <= parity_type[1];
                dbl       <= double_stop_bits;
                last_bit  <= {1'b0, data_bits_count} + 3'd4;
                bit_cnt   <= '0;
                shift     <= '0;
                par_flag  <= 1'b0;
                stop_flag <= 1'b0;
            end
            if (state == DATA && at_dec)
                shift <= {vote, shift[7:1]};
            if (state == DATA && at_last)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && at_dec)
                par_flag <= vote != (^shift ^ par_odd);
            if ((state == STOP1 || state == STOP2) && at_dec && !vote)
                stop_flag <= 1'b1;
            // Short words sit in the MSBs of shift; right-align them on completion
            if (done) begin
                rx_data        <= shift >> (3'd7 - last_bit);
                parity_error   <= par_flag;
                stop_bit_error <= stop_flag | ~vote;
            end
        end
    end
endmodule
